sigma_np_win: RTL and testbench
===============================

// Module: sigma_np_win
// PURPOSE
//  Parametrised windowed accumulator for sign-magnitude samples that arrive on a slow strobe, syn_in.
//  A sample is taken on each syn_in rising edge. The block converts it to two's complement and sums
//  N = 2**LOG2_N samples, either as non-overlapping blocks or as a sliding window, then outputs the
//  sum and mean with a one-clock sync pulse. It replaces the fixed 8-bit/16-point sigma block in the sampling chain.
// PARAMETERS
//  DATA_W   8   sample width: sign-magnitude, MSB = sign, DATA_W-1 magnitude bits
//  LOG2_N   4   window depth is N = 2**LOG2_N samples (1..8)
//  OUT_W    DATA_W+LOG2_N   sum width (derived, do not override); overflow impossible
// PORTS
//  clk       in   1       system clock, rising edge
//  res       in   1       asynchronous active-low reset
//  data_in   in   DATA_W  sample, sign-magnitude; must be stable while syn_in is high
//  syn_in    in   1       sample strobe; each 0->1 transition = one sample
//  mode      in   1       0 = block (non-overlapping), 1 = sliding window
//  data_out  out  OUT_W   two's-complement window sum
//  mean_out  out  DATA_W  data_out >>> LOG2_N, arithmetic shift (floor toward -inf)
//  syn_out   out  1       one-clock pulse when data_out/mean_out update
//  busy_fill out  1       1 until the first full window since reset or restart
// BEHAVIOUR
//  Reset (res=0, async): data_out=0, mean_out=0, syn_out=0, busy_fill=1.
//   Also clears: sum, sample count, buffer pointer, all N buffer entries, syn_in delay reg, mode reg.
//   Mid-window reset discards the partial window.
//  Edge detect: syn_d <= syn_in each clk; edge E = a clk edge with syn_in=1 and syn_d=0.
//   syn_in held high for many clocks counts as one sample.
//  Conversion at E: magnitude m = data_in[DATA_W-2:0].
//   Sign=0 gives +m. Sign=1 gives -m in two's complement. Negative zero (1000..0) gives 0.
//   Result is sign-extended to OUT_W and registered as d_r. s_v pulses at E+1.
//  Accumulate (on the s_v cycle), block mode (mode=0):
//   - cnt counts 0..N-1.
//   - cnt<N-1: sum <= sum + d_r; cnt++.
//   - cnt==N-1: data_out <= sum + d_r; sum <= 0; cnt <= 0; syn_out <= 1; busy_fill <= 0.
//  Accumulate, sliding mode (mode=1):
//   - N-entry circular buffer buf[] of DATA_W two's-complement values; wr pointer wraps N-1 -> 0.
//   - Each sample: sum <= sum + d_r - sext(buf[wr]); buf[wr] <= d_r; wr++.
//   - fill count saturates at N. busy_fill drops when the N-th sample since restart is written.
//   - data_out <= new sum and syn_out <= 1 on every sample once fill==N, including the N-th.
//   - No syn_out while busy_fill=1.
//  Latency: data_out, mean_out and syn_out change at edge E+2. syn_out is high for exactly one clk.
//   Otherwise syn_out=0 and data_out/mean_out hold their last value.
//  Minimum strobe spacing: 3 clks between rising edges. Closer edges are unsupported.
//  mode is sampled every clk into mode_r. When mode differs from mode_r, a restart occurs on that edge:
//   - sum, cnt, fill, wr and buffer are cleared; busy_fill <= 1.
//   - A sample whose E coincides with the restart edge is dropped.
//   - data_out/mean_out keep their old value.
//  Simultaneous s_v and restart: restart wins and the sample is dropped.
//  Width: d_r, sum, data_out are OUT_W signed. |sum| <= N*(2**(DATA_W-1)-1) always fits.
//  mean_out = data_out[OUT_W-1:LOG2_N].
// TESTING
//  1 DATA_W=8,LOG2_N=4, mode=0, 16 samples of 8'h01 -> one syn_out, data_out=12'h010, mean_out=8'h01.
//  2 mode=0, 16 samples of 8'h81 (-1) -> data_out=12'hFF0, mean_out=8'hFF.
//    Then 16x 8'h7F -> 12'h7F0; 16x 8'hFF -> 12'h810.
//  3 mode=0, mixed 8'h80 (-0) and 8'h03 alternating -> data_out=12'h018.
//    Check syn_out is exactly 1 clk wide and at E+2.
//  4 mode=1, ramp 1,2,..,20 -> no syn_out for samples 1-15.
//    Sums 136,152,168,184,200 for samples 16-20; busy_fill falls with the 16th.
//  5 syn_in held high 50 clks, then low, x4 -> exactly 4 samples counted.
//    res pulsed low after sample 7 of 16 -> all outputs 0; next full block is 16 fresh samples.
//  6 Toggle mode mid-window with E on the same clk -> sample dropped, busy_fill=1.
//    Old data_out held; next window counts from zero.

Source files
------------

// File: rtl/sigma_np_win.sv
// ============================================================================
// sigma_np_win : windowed (block or sliding) accumulator of sign-magnitude
//                samples taken on syn_in rising edges; emits sum and mean.
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module sigma_np_win #(
    parameter  int DATA_W = 8,
    parameter  int LOG2_N = 4,
    localparam int OUT_W  = DATA_W + LOG2_N
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     syn_in,
    input  logic                     mode,
    output logic signed [OUT_W-1:0]  data_out,
    output logic [DATA_W-1:0]        mean_out,
    output logic                     syn_out,
    output logic                     busy_fill
);

    localparam int                N         = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST  = LOG2_N'(N - 1);
    localparam logic [LOG2_N:0]   FILL_FULL = (LOG2_N + 1)'(N);
    localparam logic [LOG2_N:0]   FILL_LAST = (LOG2_N + 1)'(N - 1);

    logic                    syn_d;
    logic                    mode_r;
    logic                    pend;
    logic                    s_v;
    logic signed [OUT_W-1:0] d_r;
    logic signed [OUT_W-1:0] sum;
    logic [LOG2_N-1:0]       cnt;
    logic [LOG2_N-1:0]       wr;
    logic [LOG2_N:0]         fill;
    logic [DATA_W-1:0]       win_buf [N];

    logic                    e_det;
    logic                    restart;
    logic signed [OUT_W-1:0] conv_mag;
    logic signed [OUT_W-1:0] conv;
    logic signed [OUT_W-1:0] oldest;
    logic signed [OUT_W-1:0] blk_sum;
    logic signed [OUT_W-1:0] win_sum;

    assign e_det    = syn_in & ~syn_d;
    assign restart  = mode ^ mode_r;
    // Negating the magnitude maps negative zero to 0 for free.
    assign conv_mag = {{(LOG2_N + 1){1'b0}}, data_in[DATA_W-2:0]};
    assign conv     = data_in[DATA_W-1] ? -conv_mag : conv_mag;
    assign oldest   = {{LOG2_N{win_buf[wr][DATA_W-1]}}, win_buf[wr]};
    assign blk_sum  = sum + d_r;
    assign win_sum  = sum + d_r - oldest;
    assign mean_out = data_out[OUT_W-1:LOG2_N];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            syn_d     <= 1'b0;
            mode_r    <= 1'b0;
            pend      <= 1'b0;
            s_v       <= 1'b0;
            d_r       <= '0;
            sum       <= '0;
            cnt       <= '0;
            wr        <= '0;
            fill      <= '0;
            data_out  <= '0;
            syn_out   <= 1'b0;
            busy_fill <= 1'b1;
            for (int i = 0; i < N; i++) begin
                win_buf[i] <= '0;
            end
        end else begin
            syn_d   <= syn_in;
            mode_r  <= mode;
            syn_out <= 1'b0;
            // A sample in flight across a mode change belongs to the old mode and is dropped.
            pend    <= e_det & ~restart;
            s_v     <= pend & ~restart;
            if (e_det) begin
                d_r <= conv;
            end

            if (restart) begin
                sum       <= '0;
                cnt       <= '0;
                wr        <= '0;
                fill      <= '0;
                busy_fill <= 1'b1;
                for (int i = 0; i < N; i++) begin
                    win_buf[i] <= '0;
                end
            end else if (s_v) begin
                if (!mode_r) begin
                    if (cnt == CNT_LAST) begin
                        data_out  <= blk_sum;
                        sum       <= '0;
                        cnt       <= '0;
                        syn_out   <= 1'b1;
                        busy_fill <= 1'b0;
                    end else begin
                        sum <= blk_sum;
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    sum         <= win_sum;
                    win_buf[wr] <= d_r[DATA_W-1:0];
                    wr          <= wr + 1'b1;
                    if (fill != FILL_FULL) begin
                        fill <= fill + 1'b1;
                    end
                    if (fill >= FILL_LAST) begin
                        data_out  <= win_sum;
                        syn_out   <= 1'b1;
                        busy_fill <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sigma_np_win.sv
// Randomized scoreboard bench for sigma_np_win (DATA_W=8, LOG2_N=4).
`default_nettype none

module tb_sigma_np_win;

    localparam int DATA_W = 8;
    localparam int LOG2_N = 4;
    localparam int N      = 16;
    localparam int OUT_W  = 12;

    logic                    clk = 1'b0;
    logic                    res;
    logic [DATA_W-1:0]       data_in;
    logic                    syn_in;
    logic                    mode;
    logic signed [OUT_W-1:0] data_out;
    logic [DATA_W-1:0]       mean_out;
    logic                    syn_out;
    logic                    busy_fill;

    sigma_np_win #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk       (clk),
        .res       (res),
        .data_in   (data_in),
        .syn_in    (syn_in),
        .mode      (mode),
        .data_out  (data_out),
        .mean_out  (mean_out),
        .syn_out   (syn_out),
        .busy_fill (busy_fill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int sum; int at; } exp_t;
    exp_t sb[$];

    // Reference model: samples of the current window since the last reset/restart.
    int win[$];
    bit mdl_mode;
    bit mdl_busy;
    int last_out;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int to_val(input logic [7:0] v);
        int m;
        m = int'(v[6:0]);
        return v[7] ? -m : m;
    endfunction

    task automatic expect_out(input int s);
        sb.push_back('{s, cyc + 3});
        last_out = s;
        mdl_busy = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input int hold);
        @(negedge clk);
        data_in = v;
        syn_in  = 1'b1;
        win.push_back(to_val(v));
        if (!mdl_mode) begin
            if (win.size() == N) begin
                expect_out(win.sum());
                win.delete();
            end
        end else begin
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) expect_out(win.sum());
        end
        repeat (hold) @(negedge clk);
        syn_in = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_fill", int'(busy_fill), int'(mdl_busy));
    endtask

    // Flip mode; optionally raise syn_in on the very same clock so that sample is lost.
    task automatic toggle_mode(input bit with_edge, input logic [7:0] v);
        @(negedge clk);
        mode = ~mode;
        if (with_edge) begin
            data_in = v;
            syn_in  = 1'b1;
        end
        win.delete();
        mdl_mode = mode;
        mdl_busy = 1'b1;
        @(negedge clk);
        syn_in = 1'b0;
        repeat (2) @(negedge clk);
        check("restart_busy", int'(busy_fill), 1);
        check("restart_hold", int'(data_out), last_out);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0;
        #1;
        check("rst_data_out", int'(data_out), 0);
        check("rst_mean_out", int'(mean_out), 0);
        check("rst_syn_out", int'(syn_out), 0);
        check("rst_busy", int'(busy_fill), 1);
        win.delete();
        mdl_busy = 1'b1;
        last_out = 0;
        @(negedge clk);
        res = 1'b1;
        mdl_mode = mode;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (res && syn_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_syn_out actual=1 expected=0 data_out=%0d (cycle %0d)",
                         data_out, cyc);
            end else begin
                e = sb.pop_front();
                check("data_out", int'(data_out), e.sum);
                check("mean_out", int'($signed(mean_out)), e.sum >>> LOG2_N);
                check("latency", cyc, e.at);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        res = 1'b0; syn_in = 1'b0; data_in = '0; mode = 1'b0;
        mdl_mode = 1'b0; mdl_busy = 1'b1; last_out = 0;
        repeat (2) @(negedge clk);
        check("rst_data_out", int'(data_out), 0);
        check("rst_mean_out", int'(mean_out), 0);
        check("rst_syn_out", int'(syn_out), 0);
        check("rst_busy", int'(busy_fill), 1);
        res = 1'b1;

        // Block mode: +1, -1, +max, -max, negative zero mixed with +3
        for (int i = 0; i < N; i++) send(8'h01, 1);
        for (int i = 0; i < N; i++) send(8'h81, 1);
        for (int i = 0; i < N; i++) send(8'h7F, 1);
        for (int i = 0; i < N; i++) send(8'hFF, 2);
        for (int i = 0; i < N; i++) send((i % 2) ? 8'h03 : 8'h80, 1);

        // Sliding mode ramp 1..20
        toggle_mode(1'b0, 8'h00);
        for (int i = 1; i <= 20; i++) send(8'(i), 1);

        // Long strobes count once; reset mid-block discards the partial window
        toggle_mode(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) send(8'h05, 50);
        for (int i = 0; i < 3; i++) send(8'h85, 1);
        do_reset();
        for (int i = 0; i < N; i++) send(8'(i + 2), 1);

        // Mode change coinciding with a strobe edge drops that sample
        for (int i = 0; i < 5; i++) send(8'h10, 1);
        toggle_mode(1'b1, 8'h7F);
        for (int i = 0; i < N + 3; i++) send(8'(i), 1);

        // Randomized traffic with occasional restarts
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0)
                toggle_mode(1'($urandom_range(0, 1)), 8'($urandom));
            send(8'($urandom), $urandom_range(1, 3));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
